sprite_fetch: RTL and testbench
===============================

SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter MARIO_W, default 16: Mario sprite width in pixels.
REQ-002 SHALL have parameter MARIO_H, default 32: Mario sprite height in pixels.
REQ-003 SHALL have parameter MARIO_FRAMES, default 3: number of walk-cycle frames stored in the Mario ROM.
REQ-004 SHALL have parameter ANIM_DIV, default 6: video frames per walk-cycle step.
REQ-005 SHALL have parameter TILE, default 16: edge length in pixels of the brick tile and the background tile.
REQ-006 SHALL have ports:
- Clk  in  1: pixel clock.
- Reset  in  1: synchronous, active-high reset; one clock only, no other clock domain.
- DrawX, DrawY  in  10 each: current pixel from the VGA controller.
- blank  in  1: high while the pixel is in the visible region.
- VS  in  1: vertical sync, active-low.
- BallX, BallY, Ball_size_X, Ball_size_Y  in  10 each: Mario centre position and half-extents.
- logx  in  6: horizontal scroll offset.
- mario_left  in  1: Mario faces left.
- mario_walk  in  1: Mario is walking.
- mario_addr  out  $clog2(MARIO_W*MARIO_H*MARIO_FRAMES): synchronous Mario ROM address.
- brick_addr, bg_addr  out  $clog2(TILE*TILE) each: synchronous tile ROM addresses.
- mario_q, brick_q, bg_q  in  4 each: palette indices, valid 1 cycle after the address.
- red_mariodata, green_mariodata, blue_mariodata  out  8 each: Mario colour.
- red_brickdata, green_brickdata, blue_brickdata  out  8 each: brick colour.
- red_bgdata, green_bgdata, blue_bgdata  out  8 each: background colour.
- DrawX_d, DrawY_d  out  10 each: pixel coordinates delayed to align with the colour outputs.
- blank_d  out  1: blank delayed to align with the colour outputs.

Function
REQ-007 SHALL be a 3-stage pipeline:
- S1 registers the inputs and computes local coordinates.
- S2 registers the ROM addresses.
- S3 registers the palette-expanded RGB.
REQ-008 Inputs at edge N SHALL appear on the RGB outputs, DrawX_d, DrawY_d and blank_d after edge N+3 (latency 3), with 1 pixel/cycle throughput and no stalls.
REQ-009 Mario local x SHALL be lx = DrawX - BallX + Ball_size_X - 1, and local y SHALL be ly = DrawY - BallY + Ball_size_Y - 1, both computed modulo 2^10.
REQ-010 Mario local coordinates outside 0..MARIO_W-1 or 0..MARIO_H-1 SHALL force mario_addr = 0.
REQ-011 With the latched facing-left flag set, the column used SHALL be MARIO_W-1-lx (horizontal flip).
REQ-012 mario_addr SHALL be frame*MARIO_W*MARIO_H + ly*MARIO_W + column.
REQ-013 brick_addr SHALL be ((DrawY-301) mod TILE)*TILE + ((DrawX+logx-221) mod TILE).
REQ-014 bg_addr SHALL be (DrawY mod TILE)*TILE + ((DrawX+logx) mod TILE).
REQ-015 The frame boundary SHALL be the cycle after VS is sampled 1 having been 0 on the previous cycle (rising edge, detected through one register).
REQ-016 mario_left and mario_walk SHALL be latched only at a frame boundary; mid-frame changes SHALL have no effect until the next boundary.
REQ-017 Animation state machine: STAND and WALK.
- STAND: frame = 0 and divider = 0; moves to WALK at a frame boundary where mario_walk = 1.
- WALK: the divider increments at each frame boundary; on reaching ANIM_DIV-1 it clears and frame increments, wrapping MARIO_FRAMES-1 -> 0.
- WALK returns to STAND at a frame boundary where mario_walk = 0, clearing frame and divider in the same cycle.
REQ-018 Palette index 0 SHALL map to the transparency key FE/06/FF on the Mario and brick channels.
REQ-019 The bg ROM SHALL never contain index 0 entries; if bg_q = 0 the bg output SHALL be the key.
REQ-020 While blank at S3 input is 0, all RGB outputs SHALL be 0; the addresses still advance.
REQ-021 logx wrap-around: DrawX+logx SHALL be computed at 11 bits, with no truncation before the modulo.

Reset
REQ-022 On Reset sampled high, the following SHALL be 0 at the next edge: all RGB outputs, DrawX_d, DrawY_d, blank_d, all addresses, frame, divider, the latched facing flag and the latched walk flag; the state machine SHALL be in STAND.
REQ-023 The VS edge register SHALL reset to 1 so that no boundary is detected on the first cycle after reset.
REQ-024 Reset mid-line SHALL flush the pipeline; outputs SHALL be 0 until 3 valid cycles have elapsed after deassertion.

Structure
REQ-025 Package sprite_pkg SHALL hold:
- The 16-entry 24-bit palette constants for Mario, brick and background.
- The transparency key FE06FF.
- The brick box constants 220/310/300/320.
- The animation state enum.
REQ-026 One sub-module, sprite_palette, SHALL perform the registered 4-bit-to-24-bit lookup and SHALL be instantiated three times in S3.

Verification
REQ-027 Ball at 100/200, size 8/16, right-facing, DrawX=93, DrawY=185 -> mario_addr = 0 two cycles later; RGB of palette[mario_q] on the third cycle.
REQ-028 Same pixel with mario_left latched -> column 15, mario_addr = 15.
REQ-029 mario_walk = 1 held, 18 VS rising edges -> frame sequence 0,1,2,0 at boundaries 6,12,18 (divider wraps at 6).
REQ-030 mario_left toggled mid-frame -> addresses unchanged until the next VS rising edge.
REQ-031 logx = 63, DrawX = 639 -> bg column (702 mod 16) = 14, no 10-bit truncation.
REQ-032 Reset asserted during a visible line -> all outputs 0 next edge; blank_d follows blank exactly 3 cycles after Reset falls.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite fetch pipeline.
//   - 24-bit RGB palettes (16 entries each) for Mario, brick and background
//   - transparency key returned for palette index 0
//   - brick box corners used to anchor the brick tile grid
//   - animation state type and the palette lookup helper
package sprite_pkg;

    localparam logic [23:0] KEY_RGB = 24'hFE06FF;

    // Brick box: x 220..310, y 300..320. The tile grid starts one pixel
    // inside the top-left corner.
    localparam int BRICK_X0 = 220;
    localparam int BRICK_X1 = 310;
    localparam int BRICK_Y0 = 300;
    localparam int BRICK_Y1 = 320;

    typedef enum logic {
        ST_STAND = 1'b0,
        ST_WALK  = 1'b1
    } anim_state_t;

    localparam int PAL_MARIO = 0;
    localparam int PAL_BRICK = 1;
    localparam int PAL_BG    = 2;

    localparam logic [23:0] MARIO_PAL [16] = '{
        24'hFE06FF, 24'h000000, 24'hB13425, 24'h6A6B04,
        24'hE39D25, 24'hFFFFFF, 24'hFE6C00, 24'h7F7F7F,
        24'hD82800, 24'hFCBCB0, 24'h0058F8, 24'h3CBCFC,
        24'h00A800, 24'hF8D878, 24'h503000, 24'h881400
    };

    localparam logic [23:0] BRICK_PAL [16] = '{
        24'hFE06FF, 24'h000000, 24'h9C4A00, 24'hFFCEC5,
        24'hC84C0C, 24'hE09050, 24'h884000, 24'h602000,
        24'hFCA044, 24'hA0A0A0, 24'h505050, 24'hFFFFFF,
        24'h7C0800, 24'hB85800, 24'hF0D0B0, 24'h402000
    };

    localparam logic [23:0] BG_PAL [16] = '{
        24'hFE06FF, 24'h5C94FC, 24'hFFFFFF, 24'h3CBCFC,
        24'h00A800, 24'h80D010, 24'h000000, 24'hB8F818,
        24'hA4E4FC, 24'h0058F8, 24'h6888FC, 24'hD8F878,
        24'h58D854, 24'hF8F8F8, 24'h003800, 24'h9290FF
    };

    // Index 0 is always the transparency key, whichever table is selected.
    // The bg ROM should never hold index 0; if it does, the key shows it.
    function automatic logic [23:0] pal_lookup(input int sel, input logic [3:0] idx);
        logic [23:0] c;
        c = KEY_RGB;
        if (idx != 4'd0) begin
            case (sel)
                PAL_MARIO: c = MARIO_PAL[idx];
                PAL_BRICK: c = BRICK_PAL[idx];
                default:   c = BG_PAL[idx];
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// ROM bus between sprite_fetch and the three sprite/tile ROMs.
//   mario_addr, brick_addr, bg_addr : registered ROM addresses (fetcher -> ROM)
//   mario_q, brick_q, bg_q          : 4-bit palette indices (ROM -> fetcher),
//                                     valid the cycle after the address
interface sprite_fetch_if #(
    parameter int MA_W = 11,
    parameter int TA_W = 8
);
    logic [MA_W-1:0] mario_addr;
    logic [TA_W-1:0] brick_addr;
    logic [TA_W-1:0] bg_addr;
    logic [3:0]      mario_q;
    logic [3:0]      brick_q;
    logic [3:0]      bg_q;

    modport master (
        output mario_addr, brick_addr, bg_addr,
        input  mario_q, brick_q, bg_q
    );

    modport slave (
        input  mario_addr, brick_addr, bg_addr,
        output mario_q, brick_q, bg_q
    );
endinterface

// File: rtl/sprite_palette.sv
// Registered 4-bit palette index to 24-bit RGB expansion.
//   clk, rst       : pixel clock, synchronous active-high reset
//   en_i           : pixel visible; when low the registered colour is black
//   idx_i          : palette index from the ROM
//   red_o/green_o/blue_o : registered colour channels
module sprite_palette
    import sprite_pkg::*;
#(
    parameter int PAL_SEL = PAL_MARIO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [3:0] idx_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o
);

    logic [23:0] rgb_d;
    logic [23:0] rgb_q;

    always_comb begin
        rgb_d = 24'h000000;
        if (en_i) begin
            rgb_d = pal_lookup(PAL_SEL, idx_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red_o   = rgb_q[23:16];
    assign green_o = rgb_q[15:8];
    assign blue_o  = rgb_q[7:0];

endmodule

// File: rtl/sprite_fetch.sv
// Three-stage sprite/tile fetch pipeline for the VGA renderer.
//   Clk, Reset              : pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank, VS : raster position, visible flag, vsync (active-low)
//   BallX/Y, Ball_size_X/Y  : Mario centre and half-extents
//   logx                    : horizontal scroll offset
//   mario_left, mario_walk  : facing / walking, latched once per video frame
//   *_addr / *_q            : synchronous ROM addresses and returned indices
//   *_mariodata, *_brickdata, *_bgdata : palette-expanded RGB
//   DrawX_d, DrawY_d, blank_d : raster info aligned with the RGB outputs
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int MARIO_W      = 16,
    parameter int MARIO_H      = 32,
    parameter int MARIO_FRAMES = 3,
    parameter int ANIM_DIV     = 6,
    parameter int TILE         = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       VS,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] Ball_size_X,
    input  logic [9:0] Ball_size_Y,
    input  logic [5:0] logx,
    input  logic       mario_left,
    input  logic       mario_walk,
    output logic [$clog2(MARIO_W*MARIO_H*MARIO_FRAMES)-1:0] mario_addr,
    output logic [$clog2(TILE*TILE)-1:0] brick_addr,
    output logic [$clog2(TILE*TILE)-1:0] bg_addr,
    input  logic [3:0] mario_q,
    input  logic [3:0] brick_q,
    input  logic [3:0] bg_q,
    output logic [7:0] red_mariodata,
    output logic [7:0] green_mariodata,
    output logic [7:0] blue_mariodata,
    output logic [7:0] red_brickdata,
    output logic [7:0] green_brickdata,
    output logic [7:0] blue_brickdata,
    output logic [7:0] red_bgdata,
    output logic [7:0] green_bgdata,
    output logic [7:0] blue_bgdata,
    output logic [9:0] DrawX_d,
    output logic [9:0] DrawY_d,
    output logic       blank_d
);

    localparam int MA_W = $clog2(MARIO_W*MARIO_H*MARIO_FRAMES);
    localparam int TA_W = $clog2(TILE*TILE);
    localparam int TW   = $clog2(TILE);
    localparam int FR_W = (MARIO_FRAMES > 1) ? $clog2(MARIO_FRAMES) : 1;
    localparam int DV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // ---------------- frame boundary and animation ----------------
    // vs_q resets to 1 so a VS already high out of reset is not an edge.
    // The edge latches the facing/walk flags and arms bnd_q; the FSM then
    // acts on the latched walk flag one cycle later.
    logic              vs_q;
    logic              vs_rise;
    logic              bnd_q;
    logic              left_q, left_d;
    logic              walk_q, walk_d;
    anim_state_t       state_q, state_d;
    logic [FR_W-1:0]   frame_q, frame_d;
    logic [DV_W-1:0]   div_q, div_d;

    assign vs_rise = VS & ~vs_q;

    always_comb begin
        left_d  = left_q;
        walk_d  = walk_q;
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        if (vs_rise) begin
            left_d = mario_left;
            walk_d = mario_walk;
        end
        if (bnd_q) begin
            if (!walk_q) begin
                state_d = ST_STAND;
                frame_d = '0;
                div_d   = '0;
            end else begin
                // Entering WALK counts as the first divider tick.
                state_d = ST_WALK;
                if (div_q == DV_W'(ANIM_DIV-1)) begin
                    div_d   = '0;
                    frame_d = (frame_q == FR_W'(MARIO_FRAMES-1)) ? '0 : frame_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q    <= 1'b1;
            bnd_q   <= 1'b0;
            left_q  <= 1'b0;
            walk_q  <= 1'b0;
            state_q <= ST_STAND;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            vs_q    <= VS;
            bnd_q   <= vs_rise;
            left_q  <= left_d;
            walk_q  <= walk_d;
            state_q <= state_d;
            frame_q <= frame_d;
            div_q   <= div_d;
        end
    end

    // ---------------- S1: register inputs, local coordinates ----------------
    logic [9:0]    lx_s1, ly_s1;
    logic [10:0]   bgx_sum, brx_sum, bry_diff;
    logic [9:0]    drawx_p1, drawy_p1;
    logic          blank_p1;
    logic [9:0]    lx_p1, ly_p1;
    logic          mario_in_p1;
    logic [TW-1:0] bg_row_p1, bg_col_p1, br_row_p1, br_col_p1;

    // Scroll sum kept at 11 bits so DrawX+logx never truncates before the modulo.
    always_comb begin
        lx_s1    = DrawX - BallX + Ball_size_X - 10'd1;
        ly_s1    = DrawY - BallY + Ball_size_Y - 10'd1;
        bgx_sum  = {1'b0, DrawX} + {5'b0, logx};
        brx_sum  = bgx_sum - 11'(BRICK_X0 + 1);
        bry_diff = {1'b0, DrawY} - 11'(BRICK_Y0 + 1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drawx_p1    <= '0;
            drawy_p1    <= '0;
            blank_p1    <= 1'b0;
            lx_p1       <= '0;
            ly_p1       <= '0;
            mario_in_p1 <= 1'b0;
            bg_row_p1   <= '0;
            bg_col_p1   <= '0;
            br_row_p1   <= '0;
            br_col_p1   <= '0;
        end else begin
            drawx_p1    <= DrawX;
            drawy_p1    <= DrawY;
            blank_p1    <= blank;
            lx_p1       <= lx_s1;
            ly_p1       <= ly_s1;
            mario_in_p1 <= (lx_s1 < 10'(MARIO_W)) && (ly_s1 < 10'(MARIO_H));
            bg_row_p1   <= TW'(DrawY % 10'(TILE));
            bg_col_p1   <= TW'(bgx_sum % 11'(TILE));
            br_row_p1   <= TW'(bry_diff % 11'(TILE));
            br_col_p1   <= TW'(brx_sum % 11'(TILE));
        end
    end

    // ---------------- S2: ROM addresses ----------------
    logic [9:0]      col_s2;
    logic [MA_W-1:0] mario_addr_d;
    logic [TA_W-1:0] brick_addr_d, bg_addr_d;
    logic [MA_W-1:0] mario_addr_q;
    logic [TA_W-1:0] brick_addr_q, bg_addr_q;
    logic [9:0]      drawx_p2, drawy_p2;
    logic            blank_p2;

    always_comb begin
        col_s2       = left_q ? (10'(MARIO_W-1) - lx_p1) : lx_p1;
        mario_addr_d = '0;
        if (mario_in_p1) begin
            mario_addr_d = MA_W'(frame_q) * MA_W'(MARIO_W*MARIO_H)
                         + MA_W'(ly_p1) * MA_W'(MARIO_W) + MA_W'(col_s2);
        end
        brick_addr_d = TA_W'(br_row_p1) * TA_W'(TILE) + TA_W'(br_col_p1);
        bg_addr_d    = TA_W'(bg_row_p1) * TA_W'(TILE) + TA_W'(bg_col_p1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mario_addr_q <= '0;
            brick_addr_q <= '0;
            bg_addr_q    <= '0;
            drawx_p2     <= '0;
            drawy_p2     <= '0;
            blank_p2     <= 1'b0;
        end else begin
            mario_addr_q <= mario_addr_d;
            brick_addr_q <= brick_addr_d;
            bg_addr_q    <= bg_addr_d;
            drawx_p2     <= drawx_p1;
            drawy_p2     <= drawy_p1;
            blank_p2     <= blank_p1;
        end
    end

    assign mario_addr = mario_addr_q;
    assign brick_addr = brick_addr_q;
    assign bg_addr    = bg_addr_q;

    // ---------------- S3: palette expansion ----------------
    logic [9:0] drawx_p3, drawy_p3;
    logic       blank_p3;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drawx_p3 <= '0;
            drawy_p3 <= '0;
            blank_p3 <= 1'b0;
        end else begin
            drawx_p3 <= drawx_p2;
            drawy_p3 <= drawy_p2;
            blank_p3 <= blank_p2;
        end
    end

    sprite_palette #(.PAL_SEL(PAL_MARIO)) u_pal_mario (
        .clk(Clk), .rst(Reset), .en_i(blank_p2), .idx_i(mario_q),
        .red_o(red_mariodata), .green_o(green_mariodata), .blue_o(blue_mariodata)
    );

    sprite_palette #(.PAL_SEL(PAL_BRICK)) u_pal_brick (
        .clk(Clk), .rst(Reset), .en_i(blank_p2), .idx_i(brick_q),
        .red_o(red_brickdata), .green_o(green_brickdata), .blue_o(blue_brickdata)
    );

    sprite_palette #(.PAL_SEL(PAL_BG)) u_pal_bg (
        .clk(Clk), .rst(Reset), .en_i(blank_p2), .idx_i(bg_q),
        .red_o(red_bgdata), .green_o(green_bgdata), .blue_o(blue_bgdata)
    );

    assign DrawX_d = drawx_p3;
    assign DrawY_d = drawy_p3;
    assign blank_d = blank_p3;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed testbench for sprite_fetch: reset state, pipeline latency,
// Mario window/flip/animation, tile addressing with scroll, blanking and
// mid-line reset.
module tb_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       blank, VS;
    logic [9:0] BallX, BallY, Ball_size_X, Ball_size_Y;
    logic [5:0] logx;
    logic       mario_left, mario_walk;
    logic [7:0] red_mariodata, green_mariodata, blue_mariodata;
    logic [7:0] red_brickdata, green_brickdata, blue_brickdata;
    logic [7:0] red_bgdata, green_bgdata, blue_bgdata;
    logic [9:0] DrawX_d, DrawY_d;
    logic       blank_d;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    sprite_fetch_if #(.MA_W(11), .TA_W(8)) rom ();

    sprite_fetch dut (
        .Clk(Clk), .Reset(Reset),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .VS(VS),
        .BallX(BallX), .BallY(BallY), .Ball_size_X(Ball_size_X), .Ball_size_Y(Ball_size_Y),
        .logx(logx), .mario_left(mario_left), .mario_walk(mario_walk),
        .mario_addr(rom.mario_addr), .brick_addr(rom.brick_addr), .bg_addr(rom.bg_addr),
        .mario_q(rom.mario_q), .brick_q(rom.brick_q), .bg_q(rom.bg_q),
        .red_mariodata(red_mariodata), .green_mariodata(green_mariodata), .blue_mariodata(blue_mariodata),
        .red_brickdata(red_brickdata), .green_brickdata(green_brickdata), .blue_brickdata(blue_brickdata),
        .red_bgdata(red_bgdata), .green_bgdata(green_bgdata), .blue_bgdata(blue_bgdata),
        .DrawX_d(DrawX_d), .DrawY_d(DrawY_d), .blank_d(blank_d)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic vs_pulse();
        VS = 1'b0;
        tick(1);
        VS = 1'b1;
        tick(1);
    endtask

    task automatic pix_addr(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic [31:0] exp_addr);
        DrawX = x;
        DrawY = y;
        tick(2);
        check_val(tag, 32'(rom.mario_addr), exp_addr);
    endtask

    initial begin
        Reset       = 1'b1;
        DrawX       = 10'd93;
        DrawY       = 10'd185;
        blank       = 1'b1;
        VS          = 1'b1;
        BallX       = 10'd100;
        BallY       = 10'd200;
        Ball_size_X = 10'd8;
        Ball_size_Y = 10'd16;
        logx        = 6'd0;
        mario_left  = 1'b0;
        mario_walk  = 1'b0;
        rom.mario_q = 4'd8;
        rom.brick_q = 4'd4;
        rom.bg_q    = 4'd1;

        // Reset state
        tick(2);
        check_val("rst_mario_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'h0);
        check_val("rst_brick_rgb", {8'h0, red_brickdata, green_brickdata, blue_brickdata}, 32'h0);
        check_val("rst_bg_rgb", {8'h0, red_bgdata, green_bgdata, blue_bgdata}, 32'h0);
        check_val("rst_drawx_d", 32'(DrawX_d), 32'h0);
        check_val("rst_blank_d", 32'(blank_d), 32'h0);
        check_val("rst_mario_addr", 32'(rom.mario_addr), 32'h0);
        check_val("rst_bg_addr", 32'(rom.bg_addr), 32'h0);

        // First pixel: addresses after two edges, RGB after three
        Reset = 1'b0;
        tick(2);
        check_val("lat2_mario_addr", 32'(rom.mario_addr), 32'd0);
        check_val("lat2_bg_addr", 32'(rom.bg_addr), 32'd157);
        check_val("lat2_brick_addr", 32'(rom.brick_addr), 32'd192);
        check_val("lat2_blank_d", 32'(blank_d), 32'd0);
        check_val("lat2_mario_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'h0);
        tick(1);
        check_val("lat3_mario_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'hD82800);
        check_val("lat3_brick_rgb", {8'h0, red_brickdata, green_brickdata, blue_brickdata}, 32'hC84C0C);
        check_val("lat3_bg_rgb", {8'h0, red_bgdata, green_bgdata, blue_bgdata}, 32'h5C94FC);
        check_val("lat3_drawx_d", 32'(DrawX_d), 32'd93);
        check_val("lat3_drawy_d", 32'(DrawY_d), 32'd185);
        check_val("lat3_blank_d", 32'(blank_d), 32'd1);

        // Transparency key on index 0
        rom.mario_q = 4'd0;
        rom.bg_q    = 4'd0;
        tick(1);
        check_val("key_mario_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'hFE06FF);
        check_val("key_bg_rgb", {8'h0, red_bgdata, green_bgdata, blue_bgdata}, 32'hFE06FF);
        rom.mario_q = 4'd8;
        rom.bg_q    = 4'd1;

        // Mario window edges
        pix_addr("win_lx3_ly2", 10'd96, 10'd187, 32'd35);
        pix_addr("win_lx15", 10'd108, 10'd187, 32'd47);
        pix_addr("win_lx16_out", 10'd109, 10'd187, 32'd0);
        pix_addr("win_ly31", 10'd96, 10'd216, 32'd499);
        pix_addr("win_ly32_out", 10'd96, 10'd217, 32'd0);
        pix_addr("win_lx_neg_out", 10'd92, 10'd187, 32'd0);

        // Blanked pixel: black output, address still advances
        blank = 1'b0;
        DrawX = 10'd96;
        DrawY = 10'd187;
        tick(3);
        check_val("blank_mario_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'h0);
        check_val("blank_bg_rgb", {8'h0, red_bgdata, green_bgdata, blue_bgdata}, 32'h0);
        check_val("blank_mario_addr", 32'(rom.mario_addr), 32'd35);
        check_val("blank_blank_d", 32'(blank_d), 32'd0);
        blank = 1'b1;

        // Scroll wrap: 639+63 = 702
        logx  = 6'd63;
        DrawX = 10'd639;
        DrawY = 10'd0;
        tick(2);
        check_val("scroll_bg_addr", 32'(rom.bg_addr), 32'd14);
        check_val("scroll_brick_addr", 32'(rom.brick_addr), 32'd49);
        logx = 6'd0;

        // Facing flag only takes effect at a VS rising edge
        DrawX = 10'd93;
        DrawY = 10'd185;
        mario_left = 1'b1;
        tick(3);
        check_val("left_midframe", 32'(rom.mario_addr), 32'd0);
        vs_pulse();
        tick(2);
        check_val("left_latched", 32'(rom.mario_addr), 32'd15);
        mario_left = 1'b0;
        tick(3);
        check_val("left_hold", 32'(rom.mario_addr), 32'd15);
        vs_pulse();
        tick(2);
        check_val("left_cleared", 32'(rom.mario_addr), 32'd0);

        // Walk cycle: frame = (boundary/6) mod 3, frame stride 512
        mario_walk = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            vs_pulse();
            tick(2);
            if ((k % 6 == 0) || (k % 6 == 5)) begin
                check_val($sformatf("walk_b%0d", k), 32'(rom.mario_addr), 32'(((k / 6) % 3) * 512));
            end
        end
        mario_walk = 1'b0;
        vs_pulse();
        tick(2);
        check_val("walk_stop", 32'(rom.mario_addr), 32'd0);

        // Reset in the middle of a visible line
        DrawX = 10'd96;
        DrawY = 10'd187;
        tick(3);
        check_val("pre_rst_addr", 32'(rom.mario_addr), 32'd35);
        Reset = 1'b1;
        tick(1);
        check_val("midrst_mario_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'h0);
        check_val("midrst_blank_d", 32'(blank_d), 32'd0);
        check_val("midrst_drawx_d", 32'(DrawX_d), 32'd0);
        check_val("midrst_mario_addr", 32'(rom.mario_addr), 32'd0);
        check_val("midrst_brick_addr", 32'(rom.brick_addr), 32'd0);
        Reset = 1'b0;
        tick(2);
        check_val("post_rst_blank2", 32'(blank_d), 32'd0);
        tick(1);
        check_val("post_rst_blank3", 32'(blank_d), 32'd1);
        check_val("post_rst_drawx_d", 32'(DrawX_d), 32'd96);
        check_val("post_rst_rgb", {8'h0, red_mariodata, green_mariodata, blue_mariodata}, 32'hD82800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
